// File: rtl/frv_gpr_wb_arbiter.sv
// GPR write-port arbiter: in-order writeback (A) has priority over long-latency completions (B).
// Define FRV_GPR_ARB_STARVE_EN to add the starvation counter that forces a held B entry through.
module frv_gpr_wb_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            g_clk,
    input  logic            g_resetn,
    input  logic            a_valid,
    output logic            a_ready,
    input  logic [4:0]      a_rd,
    input  logic [XLEN-1:0] a_wdata,
    input  logic            b_valid,
    output logic            b_ready,
    input  logic [4:0]      b_rd,
    input  logic [XLEN-1:0] b_wdata,
    output logic            pend_valid,
    output logic [4:0]      pend_rd,
    output logic            gpr_wen,
    output logic [4:0]      gpr_rd,
    output logic [XLEN-1:0] gpr_wdata
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("frv_gpr_wb_arbiter: STARVE_LIMIT must be in 1..15");
    end

    logic            held;
    logic [4:0]      h_rd;
    logic [XLEN-1:0] h_wdata;

    logic            force_b;
    logic            grant_a;
    logic            grant_b;
    logic            b_accept;
    logic            b_keep;
    logic            kill;
    logic [4:0]      win_rd;
    logic [XLEN-1:0] win_wdata;

`ifdef FRV_GPR_ARB_STARVE_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve;

    assign force_b = held && (starve == LIMIT);

    // Counts cycles a held entry loses to A; restarts for every new entry.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            starve <= 4'd0;
        end else if (!held || grant_b || kill) begin
            starve <= 4'd0;
        end else if (starve != LIMIT) begin
            starve <= starve + 4'd1;
        end
    end
`else
    assign force_b = 1'b0;
`endif

    assign a_ready = !force_b;
    assign grant_a = a_valid && !force_b;
    assign grant_b = force_b || (held && !a_valid);

    // Draining and refilling the buffer in one cycle avoids a bubble on B.
    assign b_ready  = !held || grant_b;
    assign b_accept = b_valid && b_ready;
    assign b_keep   = b_accept && (b_rd != 5'd0);

    // A newer A write to the held register makes the held value dead.
    assign kill = grant_a && held && (a_rd == h_rd) && (h_rd != 5'd0);

    always_comb begin
        win_rd    = a_rd;
        win_wdata = a_wdata;
        if (grant_b) begin
            win_rd    = h_rd;
            win_wdata = h_wdata;
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            held    <= 1'b0;
            h_rd    <= 5'd0;
            h_wdata <= '0;
        end else if (b_keep) begin
            held    <= 1'b1;
            h_rd    <= b_rd;
            h_wdata <= b_wdata;
        end else if (grant_b || kill) begin
            held    <= 1'b0;
        end
    end

    // Writes to x0 are dropped; rd/wdata keep their last written values.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            gpr_wen   <= 1'b0;
            gpr_rd    <= 5'd0;
            gpr_wdata <= '0;
        end else if ((grant_a || grant_b) && (win_rd != 5'd0)) begin
            gpr_wen   <= 1'b1;
            gpr_rd    <= win_rd;
            gpr_wdata <= win_wdata;
        end else begin
            gpr_wen   <= 1'b0;
        end
    end

    assign pend_valid = held;
    assign pend_rd    = h_rd;

endmodule

// File: tb/tb_frv_gpr_wb_arbiter.sv
// Self-checking bench for frv_gpr_wb_arbiter: expected GPR writes are queued at stimulus time
// and popped by a monitor whenever gpr_wen is seen.
module tb_frv_gpr_wb_arbiter;

    localparam int XLEN = 32;

    logic            g_clk;
    logic            g_resetn;
    logic            a_valid;
    logic            a_ready;
    logic [4:0]      a_rd;
    logic [XLEN-1:0] a_wdata;
    logic            b_valid;
    logic            b_ready;
    logic [4:0]      b_rd;
    logic [XLEN-1:0] b_wdata;
    logic            pend_valid;
    logic [4:0]      pend_rd;
    logic            gpr_wen;
    logic [4:0]      gpr_rd;
    logic [XLEN-1:0] gpr_wdata;

    int checks   = 0;
    int failures = 0;

    logic [36:0] sb[$];
    logic [36:0] mon_exp;

    frv_gpr_wb_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(4)) dut (
        .g_clk     (g_clk),
        .g_resetn  (g_resetn),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_rd      (a_rd),
        .a_wdata   (a_wdata),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_rd      (b_rd),
        .b_wdata   (b_wdata),
        .pend_valid(pend_valid),
        .pend_rd   (pend_rd),
        .gpr_wen   (gpr_wen),
        .gpr_rd    (gpr_rd),
        .gpr_wdata (gpr_wdata)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    // Every observed write must match the oldest outstanding expected write.
    always @(negedge g_clk) begin
        if (g_resetn === 1'b1 && gpr_wen !== 1'b0) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_write: got wen=%b rd=%0d data=%h, required no write",
                         gpr_wen, gpr_rd, gpr_wdata);
            end else begin
                mon_exp = sb.pop_front();
                if (gpr_wen !== 1'b1 || {gpr_rd, gpr_wdata} !== mon_exp) begin
                    failures++;
                    $display("[TB] FAIL write_data: got rd=%0d data=%h, required rd=%0d data=%h",
                             gpr_rd, gpr_wdata, mon_exp[36:32], mon_exp[31:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_valid = 1'b0;
        a_rd    = 5'd0;
        a_wdata = '0;
        b_valid = 1'b0;
        b_rd    = 5'd0;
        b_wdata = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        g_resetn = 1'b0;
        #3;
        checks++;
        if ({gpr_wen, gpr_rd, gpr_wdata, pend_valid, pend_rd, a_ready, b_ready} !==
            {1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b1}) begin
            failures++;
            $display("[TB] FAIL reset_values: got wen=%b rd=%0d data=%h pv=%b prd=%0d ar=%b br=%b, required 0 0 0 0 0 1 1",
                     gpr_wen, gpr_rd, gpr_wdata, pend_valid, pend_rd, a_ready, b_ready);
        end
        tick();
        tick();
        g_resetn = 1'b1;
        tick();
    endtask

    task automatic test_a_only();
        a_valid = 1'b1;
        a_rd    = 5'd5;
        a_wdata = 32'hDEADBEEF;
        checks++;
        if (a_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL a_only_ready: got %b, required 1", a_ready);
        end
        sb.push_back({5'd5, 32'hDEADBEEF});
        tick();
        a_rd    = 5'd0;
        a_wdata = 32'h11111111;
        checks++;
        if ({gpr_wen, gpr_rd, gpr_wdata} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
            failures++;
            $display("[TB] FAIL a_only_latency: got wen=%b rd=%0d data=%h, required 1 5 deadbeef",
                     gpr_wen, gpr_rd, gpr_wdata);
        end
        tick();
        a_valid = 1'b0;
        checks++;
        if ({gpr_wen, gpr_rd, gpr_wdata} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin
            failures++;
            $display("[TB] FAIL a_x0_write: got wen=%b rd=%0d data=%h, required 0 5 deadbeef",
                     gpr_wen, gpr_rd, gpr_wdata);
        end
        tick();
    endtask

    task automatic test_b_idle();
        b_valid = 1'b1;
        b_rd    = 5'd7;
        b_wdata = 32'h1234;
        checks++;
        if (b_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b_idle_ready: got %b, required 1", b_ready);
        end
        sb.push_back({5'd7, 32'h1234});
        tick();
        b_valid = 1'b0;
        checks++;
        if ({pend_valid, pend_rd, gpr_wen} !== {1'b1, 5'd7, 1'b0}) begin
            failures++;
            $display("[TB] FAIL b_idle_pending: got pv=%b prd=%0d wen=%b, required 1 7 0",
                     pend_valid, pend_rd, gpr_wen);
        end
        tick();
        checks++;
        if ({gpr_wen, gpr_rd, gpr_wdata, pend_valid} !== {1'b1, 5'd7, 32'h1234, 1'b0}) begin
            failures++;
            $display("[TB] FAIL b_idle_write: got wen=%b rd=%0d data=%h pv=%b, required 1 7 1234 0",
                     gpr_wen, gpr_rd, gpr_wdata, pend_valid);
        end
        tick();
    endtask

    task automatic test_waw_kill();
        b_valid = 1'b1;
        b_rd    = 5'd3;
        b_wdata = 32'h5555;
        tick();
        b_valid = 1'b0;
        a_valid = 1'b1;
        a_rd    = 5'd3;
        a_wdata = 32'hAAAA;
        sb.push_back({5'd3, 32'hAAAA});
        tick();
        a_valid = 1'b0;
        checks++;
        if ({pend_valid, gpr_wen, gpr_rd, gpr_wdata} !== {1'b0, 1'b1, 5'd3, 32'hAAAA}) begin
            failures++;
            $display("[TB] FAIL waw_kill: got pv=%b wen=%b rd=%0d data=%h, required 0 1 3 aaaa",
                     pend_valid, gpr_wen, gpr_rd, gpr_wdata);
        end
        repeat (4) tick();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("[TB] FAIL waw_drain: got %0d writes outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_drain_refill();
        b_valid = 1'b1;
        b_rd    = 5'd4;
        b_wdata = 32'h4444;
        tick();
        b_rd    = 5'd6;
        b_wdata = 32'h6666;
        checks++;
        if (b_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL refill_ready: got %b, required 1", b_ready);
        end
        sb.push_back({5'd4, 32'h4444});
        tick();
        b_valid = 1'b0;
        checks++;
        if ({gpr_wen, gpr_rd, pend_valid, pend_rd} !== {1'b1, 5'd4, 1'b1, 5'd6}) begin
            failures++;
            $display("[TB] FAIL refill_state: got wen=%b rd=%0d pv=%b prd=%0d, required 1 4 1 6",
                     gpr_wen, gpr_rd, pend_valid, pend_rd);
        end
        sb.push_back({5'd6, 32'h6666});
        tick();
        checks++;
        if ({gpr_wen, gpr_rd, pend_valid} !== {1'b1, 5'd6, 1'b0}) begin
            failures++;
            $display("[TB] FAIL refill_second: got wen=%b rd=%0d pv=%b, required 1 6 0",
                     gpr_wen, gpr_rd, pend_valid);
        end
        tick();
    endtask

    task automatic test_starvation();
        logic exp_ready;
        int   low_count;
        low_count = 0;
        b_valid = 1'b1;
        b_rd    = 5'd9;
        b_wdata = 32'h9999;
        tick();
        b_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            a_valid = 1'b1;
            a_rd    = 5'(10 + c);
            a_wdata = 32'hA000 + 32'(c);
`ifdef FRV_GPR_ARB_STARVE_EN
            exp_ready = (c != 4);
`else
            exp_ready = 1'b1;
`endif
            checks++;
            if (a_ready !== exp_ready) begin
                failures++;
                $display("[TB] FAIL starve_a_ready c=%0d: got %b, required %b", c, a_ready, exp_ready);
            end
            if (a_ready === 1'b0) low_count++;
            if (exp_ready) sb.push_back({5'(10 + c), 32'hA000 + 32'(c)});
            else           sb.push_back({5'd9, 32'h9999});
            tick();
        end
        a_valid = 1'b0;
`ifdef FRV_GPR_ARB_STARVE_EN
        checks++;
        if (low_count != 1 || pend_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL starve_force: got low=%0d pv=%b, required 1 0", low_count, pend_valid);
        end
`else
        checks++;
        if (low_count != 0 || pend_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL strict_priority: got low=%0d pv=%b, required 0 1", low_count, pend_valid);
        end
        sb.push_back({5'd9, 32'h9999});
`endif
        repeat (3) tick();
        checks++;
        if (sb.size() != 0 || pend_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL starve_drain: got %0d outstanding pv=%b, required 0 0", sb.size(), pend_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  rd;
        logic [31:0] data;
        for (int i = 0; i < 8; i++) begin
            rd   = (i == 3) ? 5'd0 : 5'(16 + i);
            data = $urandom;
            a_valid = 1'b1;
            a_rd    = rd;
            a_wdata = data;
            if (rd != 5'd0) sb.push_back({rd, data});
            tick();
        end
        a_valid = 1'b0;
        repeat (2) tick();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("[TB] FAIL back_to_back: got %0d writes outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_reset_midstream();
        b_valid = 1'b1;
        b_rd    = 5'd12;
        b_wdata = 32'hC0C0;
        tick();
        b_valid = 1'b0;
        a_valid = 1'b1;
        a_rd    = 5'd13;
        a_wdata = 32'hD0D0;
        tick();
        a_valid = 1'b0;
        checks++;
        if ({pend_valid, gpr_wen} !== 2'b11) begin
            failures++;
            $display("[TB] FAIL midreset_setup: got pv=%b wen=%b, required 1 1", pend_valid, gpr_wen);
        end
        g_resetn = 1'b0;
        #1;
        checks++;
        if ({gpr_wen, gpr_rd, gpr_wdata, pend_valid, pend_rd, a_ready, b_ready} !==
            {1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b1}) begin
            failures++;
            $display("[TB] FAIL midreset_values: got wen=%b rd=%0d data=%h pv=%b prd=%0d ar=%b br=%b, required 0 0 0 0 0 1 1",
                     gpr_wen, gpr_rd, gpr_wdata, pend_valid, pend_rd, a_ready, b_ready);
        end
        tick();
        g_resetn = 1'b1;
        repeat (6) tick();
        checks++;
        if (pend_valid !== 1'b0 || sb.size() != 0) begin
            failures++;
            $display("[TB] FAIL midreset_stale: got pv=%b outstanding=%0d, required 0 0", pend_valid, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_a_only();
        test_b_idle();
        test_waw_kill();
        test_drain_refill();
        test_starvation();
        test_back_to_back();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
